// File: rtl/miner_pkg.sv
// Shared miner types and constants: scheduler state encoding, default nonce
// width and the packet IDs used on the controller link.
package miner_pkg;

  localparam int NONCE_W_DEF = 32;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NACK  = 4'b1010;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    DISPATCH,
    DRAIN,
    FOUND,
    EXHAUSTED
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search begins at the request after the
// last granted one; clr_i rewinds so the next search starts at index 0.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q, last_d;

  always_comb begin
    int   idx;
    logic hit;
    gnt_o  = '0;
    last_d = last_q;
    hit    = 1'b0;
    idx    = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last_q) + off) % N;
      if (!hit && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        last_d     = PW'(idx);
        hit        = 1'b1;
      end
    end
    if (clr_i) last_d = PW'(N - 1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) last_q <= PW'(N - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Hands sequential nonces to idle hash cores and collects the first winner.
// Optional SCHED_HASH_CNT_EN adds hash_count (accepted completions since FLUSH).
//
// state     | meaning
// IDLE      | waiting for new_block
// FLUSH     | one cycle: quit all cores, reset nonce counter and bookkeeping
// DISPATCH  | starting idle cores with successive nonces
// DRAIN     | last nonce issued, waiting for outstanding cores to finish
// FOUND     | winner held in found_nonce until found_ack
// EXHAUSTED | full nonce space searched without a hit
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = NONCE_W_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 new_block,
  input  logic                 host_stop,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_valid,
  input  logic                 found_ack,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NONCE_W-1:0]   core_nonce,
  output logic                 core_quit,
  output logic                 searching,
  output logic                 found,
  output logic [NONCE_W-1:0]   found_nonce,
`ifdef SCHED_HASH_CNT_EN
  output logic [31:0]          hash_count,
`endif
  output logic                 exhausted
);

  sched_state_t         state_q, state_d;
  logic [NONCE_W-1:0]   next_nonce_q, next_nonce_d;
  logic [NUM_CORES-1:0] outstanding_q, outstanding_d;
  logic [NONCE_W-1:0]   tag_q [NUM_CORES];
  logic [NONCE_W-1:0]   tag_d [NUM_CORES];
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [NONCE_W-1:0]   core_nonce_q, core_nonce_d;
  logic                 core_quit_q, core_quit_d;
  logic                 searching_q, searching_d;
  logic                 found_q, found_d;
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
  logic                 exhausted_q, exhausted_d;

  logic                 active;
  logic                 dispatch_ok;
  logic [NUM_CORES-1:0] accepted, wins, req, gnt;
  logic [NONCE_W-1:0]   win_nonce;

  assign active   = (state_q == DISPATCH) || (state_q == DRAIN);
  assign accepted = active ? (core_done & outstanding_q) : '0;
  assign wins     = accepted & core_valid;

  // FLUSH already issues the first start so it lands two cycles after new_block.
  assign dispatch_ok = !new_block && !host_stop && (wins == '0) &&
                       ((state_q == FLUSH) || (state_q == DISPATCH));
  assign req = dispatch_ok ? ~(outstanding_q & ~accepted) : '0;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk   (clk),
    .n_rst (n_rst),
    .clr_i (new_block),
    .req_i (req),
    .gnt_o (gnt)
  );

  always_comb begin
    win_nonce = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (wins[i]) win_nonce = tag_q[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    next_nonce_d  = next_nonce_q;
    outstanding_d = outstanding_q;
    tag_d         = tag_q;
    core_start_d  = '0;
    core_nonce_d  = core_nonce_q;
    core_quit_d   = 1'b0;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    exhausted_d   = exhausted_q;
    if (new_block) begin
      state_d       = FLUSH;
      core_quit_d   = 1'b1;
      outstanding_d = '0;
      next_nonce_d  = '0;
      found_d       = 1'b0;
      exhausted_d   = 1'b0;
    end else if (host_stop) begin
      state_d       = IDLE;
      core_quit_d   = 1'b1;
      outstanding_d = '0;
      found_d       = 1'b0;
      exhausted_d   = 1'b0;
    end else if (wins != '0) begin
      state_d       = FOUND;
      core_quit_d   = 1'b1;
      found_d       = 1'b1;
      found_nonce_d = win_nonce;
      outstanding_d = '0;
    end else begin
      outstanding_d = outstanding_q & ~accepted;
      case (state_q)
        FLUSH: state_d = DISPATCH;
        DRAIN: begin
          if (outstanding_d == '0) begin
            exhausted_d = 1'b1;
            state_d     = EXHAUSTED;
          end
        end
        FOUND: begin
          if (found_ack) begin
            found_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
      if (gnt != '0) begin
        core_start_d  = gnt;
        core_nonce_d  = next_nonce_q;
        outstanding_d = outstanding_d | gnt;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (gnt[i]) tag_d[i] = next_nonce_q;
        end
        // The counter parks on the last nonce instead of wrapping.
        if (next_nonce_q == '1) state_d = DRAIN;
        else                    next_nonce_d = next_nonce_q + NONCE_W'(1);
      end
    end
    searching_d = (state_d == DISPATCH) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      next_nonce_q  <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) tag_q[i] <= '0;
      core_start_q  <= '0;
      core_nonce_q  <= '0;
      core_quit_q   <= 1'b0;
      searching_q   <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      exhausted_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_nonce_q  <= next_nonce_d;
      outstanding_q <= outstanding_d;
      tag_q         <= tag_d;
      core_start_q  <= core_start_d;
      core_nonce_q  <= core_nonce_d;
      core_quit_q   <= core_quit_d;
      searching_q   <= searching_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      exhausted_q   <= exhausted_d;
    end
  end

  assign core_start  = core_start_q;
  assign core_nonce  = core_nonce_q;
  assign core_quit   = core_quit_q;
  assign searching   = searching_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign exhausted   = exhausted_q;

`ifdef SCHED_HASH_CNT_EN
  logic [31:0] hash_cnt_q, hash_cnt_d;

  always_comb begin
    logic [32:0] sum;
    sum = {1'b0, hash_cnt_q} + 33'($countones(accepted));
    if (new_block)      hash_cnt_d = '0;
    else if (host_stop) hash_cnt_d = hash_cnt_q;
    else if (sum[32])   hash_cnt_d = '1;
    else                hash_cnt_d = sum[31:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) hash_cnt_q <= '0;
    else        hash_cnt_q <= hash_cnt_d;
  end

  assign hash_count = hash_cnt_q;
`endif

endmodule

// File: tb/tb_nonce_scheduler.sv
// Testbench for nonce_scheduler: behavioural model compared every cycle plus
// directed literal checks. Uses a 4-bit nonce so exhaustion is reachable.
module tb_nonce_scheduler;

  localparam int NC = 4;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          new_block = 1'b0, host_stop = 1'b0, found_ack = 1'b0;
  logic [NC-1:0] core_done = '0, core_valid = '0;
  logic [NC-1:0] core_start;
  logic [NW-1:0] core_nonce, found_nonce;
  logic          core_quit, searching, found, exhausted;
`ifdef SCHED_HASH_CNT_EN
  logic [31:0]   hash_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nonce_scheduler #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .new_block   (new_block),
    .host_stop   (host_stop),
    .core_done   (core_done),
    .core_valid  (core_valid),
    .found_ack   (found_ack),
    .core_start  (core_start),
    .core_nonce  (core_nonce),
    .core_quit   (core_quit),
    .searching   (searching),
    .found       (found),
    .found_nonce (found_nonce),
`ifdef SCHED_HASH_CNT_EN
    .hash_count  (hash_count),
`endif
    .exhausted   (exhausted)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_FLUSH = 1, P_DISP = 2, P_DRAIN = 3, P_FOUND = 4, P_EXH = 5;
  int            m_phase = P_IDLE;
  int            m_next = 0;
  int            m_last = NC - 1;
  int            m_win;
  int            m_tag [NC];
  bit            m_busy [NC];
  logic [NC-1:0] e_start = '0;
  int            e_nonce = 0;
  bit            e_quit = 0, e_found = 0, e_exh = 0;
  int            e_fnonce = 0;
  int            m_cnt = 0;
  int            starts[$];

  task automatic clear_busy();
    for (int i = 0; i < NC; i++) m_busy[i] = 0;
  endtask

  task automatic model_dispatch();
    bit done_one;
    done_one = 0;
    for (int k = 1; k <= NC; k++) begin
      int c;
      c = (m_last + k) % NC;
      if (!done_one && !m_busy[c]) begin
        done_one  = 1;
        e_start   = NC'(1) << c;
        e_nonce   = m_next;
        m_tag[c]  = m_next;
        m_busy[c] = 1;
        m_last    = c;
        if (m_next == (1 << NW) - 1) m_phase = P_DRAIN;
        else                         m_next++;
      end
    end
  endtask

  task automatic model_step();
    e_start = '0;
    e_quit  = 0;
    if (!n_rst) begin
      m_phase = P_IDLE; m_next = 0; m_last = NC - 1; clear_busy();
      e_found = 0; e_fnonce = 0; e_exh = 0; m_cnt = 0;
    end else if (new_block) begin
      m_phase = P_FLUSH; e_quit = 1; clear_busy(); m_next = 0; m_last = NC - 1;
      e_found = 0; e_exh = 0; m_cnt = 0;
    end else if (host_stop) begin
      m_phase = P_IDLE; e_quit = 1; clear_busy(); e_found = 0; e_exh = 0;
    end else begin
      m_win = -1;
      if (m_phase == P_DISP || m_phase == P_DRAIN) begin
        for (int i = 0; i < NC; i++) begin
          if (core_done[i] && m_busy[i]) begin
            m_busy[i] = 0;
            m_cnt++;
            if (core_valid[i] && m_win < 0) m_win = i;
          end
        end
      end
      if (m_win >= 0) begin
        m_phase = P_FOUND; e_found = 1; e_fnonce = m_tag[m_win]; e_quit = 1; clear_busy();
      end else begin
        case (m_phase)
          P_FLUSH: begin m_phase = P_DISP; model_dispatch(); end
          P_DISP:  model_dispatch();
          P_DRAIN: begin
            bit any;
            any = 0;
            for (int i = 0; i < NC; i++) any |= m_busy[i];
            if (!any) begin e_exh = 1; m_phase = P_EXH; end
          end
          P_FOUND: if (found_ack) begin e_found = 0; m_phase = P_IDLE; end
          default: ;
        endcase
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: outputs sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (n_rst) begin
      chk("m_core_start", core_start, e_start);
      if (e_start != '0) chk("m_core_nonce", core_nonce, e_nonce);
      chk("m_core_quit", core_quit, e_quit);
      chk("m_searching", searching, (m_phase == P_DISP || m_phase == P_DRAIN));
      chk("m_found", found, e_found);
      if (e_found) chk("m_found_nonce", found_nonce, e_fnonce);
      chk("m_exhausted", exhausted, e_exh);
`ifdef SCHED_HASH_CNT_EN
      chk("m_hash_count", hash_count, m_cnt);
`endif
      if (core_start != '0) starts.push_back(int'(core_nonce));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic nb, input logic hs, input logic ack,
                       input logic [NC-1:0] d, input logic [NC-1:0] v);
    @(negedge clk);
    new_block = nb; host_stop = hs; found_ack = ack; core_done = d; core_valid = v;
    @(negedge clk);
    new_block = 0; host_stop = 0; found_ack = 0; core_done = '0; core_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) step();
    chk("rst_core_start", core_start, 0);
    chk("rst_core_quit", core_quit, 0);
    chk("rst_searching", searching, 0);
    chk("rst_found", found, 0);
    chk("rst_found_nonce", found_nonce, 0);
    chk("rst_exhausted", exhausted, 0);
    n_rst = 1'b1;
    repeat (2) step();

    // Dispatch order
    pulse(1, 0, 0, '0, '0);
    chk("flush_quit", core_quit, 1);
    chk("flush_start", core_start, 0);
    chk("flush_searching", searching, 0);
    for (int i = 0; i < NC; i++) begin
      step();
      chk("disp_start", core_start, 1 << i);
      chk("disp_nonce", core_nonce, i);
      chk("disp_searching", searching, 1);
    end
    repeat (2) begin
      step();
      chk("disp_idle_start", core_start, 0);
    end

    // Restart on invalid done, then valid result
    pulse(0, 0, 0, 4'b0100, 4'b0000);
    chk("restart_start", core_start, 4'b0100);
    chk("restart_nonce", core_nonce, 4);
    pulse(0, 0, 0, 4'b0010, 4'b0010);
    chk("found_flag", found, 1);
    chk("found_nonce", found_nonce, 1);
    chk("found_quit", core_quit, 1);
    chk("found_no_start", core_start, 0);
    step();
    chk("found_quit_once", core_quit, 0);
    chk("found_hold", found, 1);
    pulse(0, 0, 1, '0, '0);
    chk("ack_found", found, 0);
    chk("ack_searching", searching, 0);

    // Simultaneous valid: lowest index wins
    pulse(1, 0, 0, '0, '0);
    repeat (NC) step();
    pulse(0, 0, 0, 4'b1001, 4'b1001);
    chk("simul_found", found, 1);
    chk("simul_nonce", found_nonce, 0);
    pulse(0, 0, 1, '0, '0);

    // Exhaustion with 16 nonces
    starts.delete();
    pulse(1, 0, 0, '0, '0);
    repeat (NC) step();
    for (int k = 0; k < 12; k++) begin
      pulse(0, 0, 0, 4'(1 << (k % NC)), '0);
      chk("exh_start", core_start, 1 << (k % NC));
      chk("exh_nonce", core_nonce, k + 4);
    end
    chk("drain_searching", searching, 1);
    pulse(0, 0, 0, 4'b0001, '0);
    chk("drain_no_start", core_start, 0);
    chk("drain_not_exh", exhausted, 0);
    pulse(0, 0, 0, 4'b0001, 4'b0001);
    chk("stray_valid_ignored", found, 0);
    pulse(0, 0, 0, 4'b0010, '0);
    pulse(0, 0, 0, 4'b0100, '0);
    chk("drain_still", exhausted, 0);
    pulse(0, 0, 0, 4'b1000, '0);
    chk("exhausted_set", exhausted, 1);
    chk("exh_searching", searching, 0);
    step();
    chk("exhausted_hold", exhausted, 1);
    chk("exh_start_count", starts.size(), 16);
    for (int i = 0; i < starts.size() && i < 16; i++) chk("exh_seq", starts[i], i);
    pulse(1, 0, 0, '0, '0);
    chk("exh_cleared", exhausted, 0);
    chk("exh_flush_quit", core_quit, 1);
    step();
    chk("exh_restart_start", core_start, 4'b0001);
    chk("exh_restart_nonce", core_nonce, 0);

    // Priority: new_block over host_stop, then host_stop alone
    repeat (2) step();
    pulse(1, 1, 0, '0, '0);
    chk("prio_quit", core_quit, 1);
    chk("prio_searching", searching, 0);
    step();
    chk("prio_start", core_start, 4'b0001);
    chk("prio_nonce", core_nonce, 0);
    repeat (3) step();
    pulse(0, 1, 0, '0, '0);
    chk("stop_quit", core_quit, 1);
    chk("stop_searching", searching, 0);
    chk("stop_no_start", core_start, 0);
    step();
    chk("stop_quit_once", core_quit, 0);
    pulse(0, 0, 0, 4'b0001, 4'b0001);
    chk("stop_done_ignored", found, 0);
    chk("stop_idle_start", core_start, 0);

`ifdef SCHED_HASH_CNT_EN
    pulse(1, 0, 0, '0, '0);
    chk("cnt_flush", hash_count, 0);
    repeat (NC) step();
    for (int k = 0; k < 10; k++) pulse(0, 0, 0, 4'(1 << (k % NC)), '0);
    chk("cnt_ten", hash_count, 10);
    pulse(1, 0, 0, '0, '0);
    chk("cnt_cleared", hash_count, 0);
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nonce_scheduler.md
Name: nonce_scheduler

Overview:
- Shares NUM_CORES SHA-256 hash cores across one nonce search; sits between main_controller and the hash core array.
- Hands out sequential nonces to idle cores, tracks which nonce each core is working on, and collects the first valid result.
- Signals exhaustion of the nonce space. On new_block it restarts the search from nonce 0.

Parameters:
- NUM_CORES, 4, number of hash cores; must be ≥2.
- NONCE_W, 32, nonce width. The search space is 2^NONCE_W values.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- new_block  in  1  1-cycle pulse: new header loaded; flush and restart the search.
- host_stop  in  1  1-cycle pulse: abort the search and go IDLE.
- core_done  in  NUM_CORES  per-core 1-cycle pulse: the assigned nonce is finished.
- core_valid  in  NUM_CORES  qualifies core_done; the hash met target.
- found_ack  in  1  pulse: the host has consumed found_nonce.
- core_start  out  NUM_CORES  one-hot 1-cycle pulse: the selected core begins hashing core_nonce.
- core_nonce  out  NONCE_W  nonce for the started core; valid only with core_start.
- core_quit  out  1  1-cycle pulse: all cores abort.
- searching  out  1  high in DISPATCH or DRAIN.
- found  out  1  level: found_nonce is valid.
- found_nonce  out  NONCE_W  winning nonce.
- exhausted  out  1  level: the whole space was searched with no valid result.

Behaviour:
- **Reset.** All outputs and the next_nonce counter are 0, the outstanding[] bits are 0, and state is IDLE.
- **Registered outputs.** All outputs come from flops.
- **States and transitions:**
  - IDLE: waits for new_block.
  - FLUSH (1 cycle): core_quit=1, outstanding[] cleared, next_nonce=0, found and exhausted cleared; then go to DISPATCH.
  - DISPATCH: each cycle, if any core has outstanding=0, the round-robin arbiter (rr_arbiter) selects one. The search starts at the core after the last granted core. The scheduler pulses core_start[i] with core_nonce=next_nonce, stores tag[i]=next_nonce, sets outstanding[i], and increments next_nonce. At most one start per cycle. When the start of nonce 2^NONCE_W-1 is issued, go to DRAIN; the counter does not wrap.
  - DRAIN: no starts. When all outstanding[] bits are 0, set exhausted=1 and go to EXHAUSTED.
  - FOUND: found=1, found_nonce=tag of the winner. core_quit pulses in the first FOUND cycle. found_ack leads to IDLE with found cleared.
  - EXHAUSTED: holds exhausted=1 until new_block or host_stop.
- **Completion handling.**
  - In DISPATCH/DRAIN, core_done[i] clears outstanding[i].
  - If core_done[i]&core_valid[i], go to FOUND. When several cores are valid in the same cycle, the lowest index wins.
  - A completion and a start on the same core in the same cycle is legal: the core is restarted and the tag updated.
  - A valid completion on the same cycle as the final dispatch takes FOUND over DRAIN.
- **Ignored completions.** core_done is ignored for a core with outstanding=0, and in IDLE, FLUSH, FOUND and EXHAUSTED.
- **Priority** from any state: new_block, then host_stop, then valid result, then normal progress.
  - new_block always goes to FLUSH, including mid-DISPATCH, mid-FOUND and from FLUSH itself.
  - host_stop goes to IDLE with a 1-cycle core_quit pulse; outstanding[] is cleared and found/exhausted are cleared.
- **Latency.**
  - new_block sampled at edge t: FLUSH in cycle t+1; first core_start in cycle t+2.
  - Valid done at edge t: found=1 and core_quit=1 in cycle t+1.
- **Reset mid-operation.** An immediate return to reset values; no quit pulse is required.

Optional Feature:
- SCHED_HASH_CNT_EN: adds output hash_count[31:0], the number of accepted core_done pulses since the last FLUSH. It saturates at 0xFFFFFFFF and clears in FLUSH and on reset.
- Without the macro, the port and counter do not exist.

Decomposition:
- miner_pkg holds:
  - the sched_state_t enum (IDLE, FLUSH, DISPATCH, DRAIN, FOUND, EXHAUSTED);
  - the NONCE_W default constant;
  - the DATA0/ACK/NACK PID constants shared with the controller.
- Sub-module rr_arbiter (request vector in, one-hot grant out, pointer advanced on grant) is instantiated once for the idle-core selection.

Test Plan:
- **Dispatch order.** NUM_CORES=4, new_block at cycle 0 → FLUSH with core_quit at cycle 1; core_start 0001/0010/0100/1000 with nonces 0,1,2,3 at cycles 2–5; then no starts until a core_done.
- **Restart and found.** Core 2 core_done (invalid) → it is restarted next cycle with nonce 4. Then core 1 valid → found=1 with found_nonce=1, one core_quit pulse; found_ack → IDLE with found=0.
- **Simultaneous valid.** Cores 3 and 0 valid in the same cycle → found_nonce equals tag[0].
- **Exhaustion.** NONCE_W=4, never valid → exactly 16 starts with nonces 0..15; DRAIN until all 4 are done; then exhausted=1. new_block → exhausted=0 and nonce restarts at 0.
- **Priority.** new_block and host_stop in the same cycle mid-DISPATCH → FLUSH (nonce 0 again). host_stop alone → IDLE with a core_quit pulse; a later core_done is ignored and found stays 0.
- **Optional counter.** Build with SCHED_HASH_CNT_EN: 10 accepted done pulses → hash_count=10; a stray done on a non-outstanding core does not count; FLUSH → 0.
